// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the write-back stage: instruction codes and
// the two special register specifiers.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

endpackage

// File: rtl/wb_dest_decode.sv
// Combinational write-back destination decode: maps an instruction to its
// E-port (ALU result) and M-port (memory result) destination registers.
module wb_dest_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_RRMOVQ: if (cnd) dst_e = rb;
            I_IRMOVQ,
            I_OPQ:    dst_e = rb;
            I_CALL,
            I_RET,
            I_PUSHQ:  dst_e = RSP;
            I_POPQ: begin
                dst_e = RSP;
                dst_m = ra;
            end
            I_MRMOVQ: dst_m = ra;
            default:  ;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Y86 write-back register file with two combinational read ports, a retired
// write-back counter and a sticky bad-destination flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module wb_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic              stall,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [31:0]       retired_count,
    output logic              err_bad_reg
);

    localparam logic [3:0] NREGS = 4'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [31:0]       r_retired;
    logic              r_err;

    logic [3:0] w_dst_e;
    logic [3:0] w_dst_m;
    logic       w_accept;
    logic       w_we_e;
    logic       w_we_m;
    logic       w_bad;

    wb_dest_decode u_dest_decode (
        .icode (icode),
        .cnd   (cnd),
        .ra    (ra),
        .rb    (rb),
        .dst_e (w_dst_e),
        .dst_m (w_dst_m)
    );

    assign w_accept = wb_valid & ~stall & reset_n;
    // RNONE (4'hF) is never below NREGS, so one range test covers both drops.
    assign w_we_m   = w_accept & (w_dst_m < NREGS);
    assign w_we_e   = w_accept & (w_dst_e < NREGS) & (w_dst_e != w_dst_m);
    assign w_bad    = w_accept &
                      (((w_dst_e != RNONE) & (w_dst_e >= NREGS)) |
                       ((w_dst_m != RNONE) & (w_dst_m >= NREGS)));

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!reset_n)
                r_regs[i] <= '0;
            else if (w_we_m && (w_dst_m == 4'(i)))
                r_regs[i] <= val_m;
            else if (w_we_e && (w_dst_e == 4'(i)))
                r_regs[i] <= val_e;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_retired <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept)
                r_retired <= r_retired + 32'd1;
            if (w_bad)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (src_a == 4'(i))
                rd_a = r_regs[i];
            if (src_b == 4'(i))
                rd_b = r_regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_we_m && (src_a == w_dst_m))
            rd_a = val_m;
        else if (w_we_e && (src_a == w_dst_e))
            rd_a = val_e;
        if (w_we_m && (src_b == w_dst_m))
            rd_b = val_m;
        else if (w_we_e && (src_b == w_dst_e))
            rd_b = val_e;
`endif
    end

    assign retired_count = r_retired;
    assign err_bad_reg   = r_err;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// write-back traffic checked every cycle against a behavioural model.
module tb_wb_regfile;

    localparam int NR = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        stall;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [31:0] retired_count;
    logic        err_bad_reg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_regs [15];
    logic [31:0] m_cnt;
    logic        m_err;
    bit          live = 1'b0;

    wb_regfile #(.DATA_W(64), .NUM_REGS(NR)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb_valid      (wb_valid),
        .stall         (stall),
        .icode         (icode),
        .cnd           (cnd),
        .ra            (ra),
        .rb            (rb),
        .val_e         (val_e),
        .val_m         (val_m),
        .src_a         (src_a),
        .src_b         (src_b),
        .rd_a          (rd_a),
        .rd_b          (rd_b),
        .retired_count (retired_count),
        .err_bad_reg   (err_bad_reg)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Destinations straight from the instruction-set rules.
    function automatic logic [3:0] dest_e(input logic [3:0] ic, input logic c, input logic [3:0] b);
        if ((ic == 4'd2 && c) || ic == 4'd3 || ic == 4'd6) return b;
        if (ic >= 4'd8 && ic <= 4'd11) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] dest_m(input logic [3:0] ic, input logic [3:0] a);
        if (ic == 4'd5 || ic == 4'd11) return a;
        return 4'hF;
    endfunction

    function automatic bit impl(input logic [3:0] d);
        return int'(d) < NR;
    endfunction

    function automatic bit bad(input logic [3:0] d);
        return d != 4'hF && int'(d) >= NR;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [3:0] s);
        logic [63:0] v;
        v = impl(s) ? m_regs[s] : 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (wb_valid && !stall && reset_n && impl(s)) begin
            if (s == dest_m(icode, ra))
                v = val_m;
            else if (s == dest_e(icode, cnd, rb))
                v = val_e;
        end
`endif
        return v;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            live  <= 1'b1;
            m_cnt <= '0;
            m_err <= 1'b0;
            for (int i = 0; i < 15; i++) m_regs[i] <= '0;
        end else if (wb_valid && !stall) begin
            m_cnt <= m_cnt + 32'd1;
            if (bad(dest_e(icode, cnd, rb)) || bad(dest_m(icode, ra)))
                m_err <= 1'b1;
            if (impl(dest_e(icode, cnd, rb)) && dest_e(icode, cnd, rb) != dest_m(icode, ra))
                m_regs[dest_e(icode, cnd, rb)] <= val_e;
            if (impl(dest_m(icode, ra)))
                m_regs[dest_m(icode, ra)] <= val_m;
        end
    end

    always @(negedge clock) begin
        if (live) begin
            check("rd_a", rd_a, exp_rd(src_a));
            check("rd_b", rd_b, exp_rd(src_b));
            check("retired_count", {32'd0, retired_count}, {32'd0, m_cnt});
            check("err_bad_reg", {63'd0, err_bad_reg}, {63'd0, m_err});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic [3:0] ic, input logic c,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [63:0] ve, input logic [63:0] vm);
        wb_valid = v; stall = st; icode = ic; cnd = c;
        ra = a; rb = b; val_e = ve; val_m = vm;
    endtask

    initial begin
        reset_n = 1'b0;
        src_a = 4'd2; src_b = 4'd4;
        drive(1, 0, 4'd3, 0, 4'hF, 4'd2, 64'd99, 64'd0);
        step();
        step();
        reset_n = 1'b1;
        drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0);
        @(negedge clock);
        check("reset_rd_a", rd_a, 64'd0);
        check("reset_count", {32'd0, retired_count}, 64'd0);

        // irmovq 0x1234 -> r2
        step(); drive(1, 0, 4'd3, 0, 4'hF, 4'd2, 64'h1234, 64'd0);
        step(); drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0); src_a = 4'd2;
        @(negedge clock);
        check("irmovq_rd_a", rd_a, 64'h1234);
        check("irmovq_count", {32'd0, retired_count}, 64'd1);

        // popq %rsp: memory value wins
        step(); drive(1, 0, 4'd11, 0, 4'd4, 4'hF, 64'h100, 64'hBEEF);
        step(); drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0); src_a = 4'd4;
        @(negedge clock);
        check("popq_rsp", rd_a, 64'hBEEF);

        // cmov not taken
        step(); drive(1, 0, 4'd2, 0, 4'hF, 4'd3, 64'd5, 64'd0);
        step(); drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0); src_b = 4'd3;
        @(negedge clock);
        check("cmov_nt_reg", rd_b, 64'd0);
        check("cmov_nt_count", {32'd0, retired_count}, 64'd3);

        // same-cycle read of r5 while it is written
        step(); drive(1, 0, 4'd3, 0, 4'hF, 4'd5, 64'h11, 64'd0);
        step(); drive(1, 0, 4'd3, 0, 4'hF, 4'd5, 64'h77, 64'd0); src_a = 4'd5;
        @(negedge clock);
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_r5", rd_a, 64'h77);
`else
        check("same_cycle_r5", rd_a, 64'h11);
`endif
        // opq into unimplemented r10
        step(); drive(1, 0, 4'd6, 0, 4'hF, 4'd10, 64'h55, 64'd0);
        step(); drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0); src_b = 4'd10;
        @(negedge clock);
        check("bad_reg_err", {63'd0, err_bad_reg}, 64'd1);
        check("bad_reg_rd", rd_b, 64'd0);
        check("bad_reg_count", {32'd0, retired_count}, 64'd6);

        // stalled write has no effect
        step(); drive(1, 1, 4'd3, 0, 4'hF, 4'd5, 64'hDEAD, 64'd0);
        step(); drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0);
        @(negedge clock);
        check("stall_r5", rd_a, 64'h77);
        check("stall_count", {32'd0, retired_count}, 64'd6);
        check("stall_err", {63'd0, err_bad_reg}, 64'd1);

        // reset overrides a concurrent write
        step(); reset_n = 1'b0; drive(1, 0, 4'd3, 0, 4'hF, 4'd5, 64'hAA, 64'd0);
        step(); reset_n = 1'b1; drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0);
        @(negedge clock);
        check("rst_write_r5", rd_a, 64'd0);
        check("rst_write_count", {32'd0, retired_count}, 64'd0);
        check("rst_write_err", {63'd0, err_bad_reg}, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            reset_n  = ($urandom_range(0, 99) >= 2);
            wb_valid = ($urandom_range(0, 9) < 7);
            stall    = ($urandom_range(0, 3) == 0);
            icode    = 4'($urandom_range(0, 15));
            cnd      = 1'($urandom_range(0, 1));
            ra       = 4'($urandom_range(0, 15));
            rb       = 4'($urandom_range(0, 15));
            val_e    = {$urandom, $urandom};
            val_m    = {$urandom, $urandom};
            src_a    = ($urandom_range(0, 1) == 1) ? rb : 4'($urandom_range(0, 15));
            src_b    = ($urandom_range(0, 1) == 1) ? ra : 4'($urandom_range(0, 15));
        end
        step();
        drive(0, 0, 4'd0, 0, 4'hF, 4'hF, 64'd0, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 15, number of implemented registers (2..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  write-back request for current instruction.
REQ-006 SHALL have port stall  input  1  hold; blocks acceptance of wb_valid.
REQ-007 SHALL have port icode  input  4  Y86 instruction code.
REQ-008 SHALL have port cnd  input  1  condition result for cmovXX.
REQ-009 SHALL have ports ra, rb  input  4 each  register specifiers; 4'hF = RNONE.
REQ-010 SHALL have ports val_e, val_m  input  DATA_W each  ALU result, memory result.
REQ-011 SHALL have ports src_a, src_b  input  4 each  read addresses.
REQ-012 SHALL have ports rd_a, rd_b  output  DATA_W each  combinational read data; RNONE or unimplemented index reads 0.
REQ-013 SHALL have port retired_count  output  32  accepted write-back count.
REQ-014 SHALL have port err_bad_reg  output  1  sticky illegal-destination flag.

Function
REQ-015 A write-back is accepted in a cycle iff wb_valid=1, stall=0 and reset_n=1.
REQ-016 E-port destination SHALL be: rb for icode 2 when cnd=1, and for icode 3 and 6; RSP (4) for icode 8, 9, 10, 11; otherwise none.
REQ-017 M-port destination SHALL be ra for icode 5 and 11; otherwise none.
REQ-018 Accepted writes SHALL update the register file at the rising edge ending the accepting cycle (one-cycle latency).
REQ-019 When E and M destinations are equal (e.g. popq %rsp), val_m SHALL be written and val_e discarded.
REQ-020 A destination of RNONE SHALL be silently dropped.
REQ-021 A destination in NUM_REGS..14 SHALL be dropped and SHALL set err_bad_reg on the next edge.
REQ-022 retired_count SHALL increment by 1 per accepted write-back, including those with no destination, wrapping 32'hFFFF_FFFF -> 0.
REQ-023 With stall=1, no register, counter or flag SHALL change.

Reset
REQ-024 reset_n=0 at a rising edge SHALL clear all registers, retired_count and err_bad_reg to 0, overriding any concurrent write-back.
REQ-025 rd_a, rd_b SHALL read 0 in the cycle after reset.

Configuration
REQ-026 With REGFILE_BYPASS_EN defined, rd_a/rd_b SHALL return the value being written in the same cycle when src matches an accepted destination (M over E).
REQ-027 Without REGFILE_BYPASS_EN, reads SHALL return the stored pre-edge value.

Structure
REQ-028 Package y86_pkg SHALL hold icode constants, RNONE=4'hF, RSP=4'h4.
REQ-029 Destination decode SHALL be sub-module wb_dest_decode (combinational: icode, cnd, ra, rb -> dst_e, dst_m).

Verification
REQ-030 irmovq: icode=3, rb=2, val_e=0x1234, accept -> rd_a(src_a=2)=0x1234 next cycle; retired_count=1.
REQ-031 popq %rsp: icode=11, ra=4, val_e=0x100, val_m=0xBEEF -> reg4=0xBEEF.
REQ-032 cmov not taken: icode=2, cnd=0, rb=3, val_e=5 -> reg3 unchanged, retired_count increments.
REQ-033 NUM_REGS=8, icode=6, rb=10 -> no write, err_bad_reg=1 until reset_n=0.
REQ-034 stall=1 with valid write, then reset_n=0 concurrent with valid write -> no update, then all state 0.
REQ-035 Same-cycle read/write reg5=0x77: with REGFILE_BYPASS_EN rd_a=0x77 that cycle; without it, old value.
